// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 responder and host blocks.
//   - dht11_state_t : responder state encoding
//   - FRAME_BITS    : number of bits in one DHT11 frame (4 data bytes + checksum)
//   - DEF_*_US      : default protocol timings in microseconds (1 cycle = 1 us)
//   - dht11_checksum: 8-bit modulo-256 sum of the four data bytes
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_RESP_DELAY,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_t;

    localparam int FRAME_BITS = 40;

    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_WAIT_US      = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;
    localparam int DEF_END_LOW_US   = 50;

    // Carry is discarded: the result is the low byte of the sum.
    function automatic logic [7:0] dht11_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (2 cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: synthesizable DHT11 sensor model (responder side of the
// one-wire protocol). Waits for a host start pulse, then returns a 40-bit
// frame {humidity_int, humidity_dec, temp_int, temp_dec, checksum}, MSB first.
//   clk_1mhz     : 1 MHz clock, 1 cycle = 1 us
//   reset        : asynchronous active-high reset, releases the pin at once
//   sensor_pin   : open-drain bus line, driven 0 or Z only
//   humidity_*   : humidity bytes, temp_* : temperature bytes (latched per frame)
//   busy         : high from start acceptance until the frame ends
//   frame_done   : one-cycle pulse when the trailing low completes
//   frames_sent  : completed frame count, wraps 255 -> 0
// Optional build macro DHT11_CHECKSUM_ERR_INJ_EN adds input corrupt_checksum;
// when it is 1 at frame latch, checksum bit 0 is inverted for that frame.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int WAIT_US      = DEF_WAIT_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US,
    parameter int END_LOW_US   = DEF_END_LOW_US
) (
    input  logic       clk_1mhz,
    input  logic       reset,
    inout  wire        sensor_pin,
    input  logic [7:0] humidity_int,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_CHECKSUM_ERR_INJ_EN
    input  logic       corrupt_checksum,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frames_sent
);

    localparam logic [15:0] START_MIN = 16'(START_MIN_US);

    dht11_state_t            state_reg;
    logic [15:0]             cnt_reg;
    logic [5:0]              bit_idx_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    drive_low_reg;
    logic                    busy_reg;
    logic                    frame_done_reg;
    logic [7:0]              frames_sent_reg;

    logic                    pin_s;
    logic [15:0]             phase_last;
    logic                    phase_done;
    logic [7:0]              checksum;
    logic [FRAME_BITS-1:0]   frame_data;

    // Idle bus is pulled high, so the synchronizer resets to 1 to avoid a
    // spurious host-low detection straight out of reset.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_pin_sync (
        .clk (clk_1mhz),
        .rst (reset),
        .d   (sensor_pin),
        .q   (pin_s)
    );

    // Open-drain driver: only ever pulls low.
    assign sensor_pin = drive_low_reg ? 1'b0 : 1'bz;

    always_comb begin
        checksum = dht11_checksum(humidity_int, humidity_dec, temp_int, temp_dec);
`ifdef DHT11_CHECKSUM_ERR_INJ_EN
        if (corrupt_checksum) begin
            checksum[0] = ~checksum[0];
        end
`endif
    end

    assign frame_data = {humidity_int, humidity_dec, temp_int, temp_dec, checksum};

    // Last counter value of the current timed phase; the phase ends on the
    // edge where the counter holds this value, giving exactly N cycles.
    always_comb begin
        phase_last = '0;
        case (state_reg)
            ST_RESP_DELAY: phase_last = 16'(WAIT_US - 1);
            ST_RESP_LOW:   phase_last = 16'(RESP_LOW_US - 1);
            ST_RESP_HIGH:  phase_last = 16'(RESP_HIGH_US - 1);
            ST_BIT_LOW:    phase_last = 16'(BIT_LOW_US - 1);
            ST_BIT_HIGH:   phase_last = shift_reg[FRAME_BITS-1] ? 16'(BIT1_HIGH_US - 1)
                                                                : 16'(BIT0_HIGH_US - 1);
            ST_END_LOW:    phase_last = 16'(END_LOW_US - 1);
            default:       phase_last = '0;
        endcase
    end

    assign phase_done = (cnt_reg == phase_last);

    // drive_low_reg is set on the same edge as the state that needs it, so
    // the pin follows the state register with no extra cycle.
    always_ff @(posedge clk_1mhz or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            drive_low_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!pin_s) begin
                        state_reg <= ST_HOST_LOW;
                        cnt_reg   <= '0;
                    end
                end
                ST_HOST_LOW: begin
                    if (!pin_s) begin
                        if (cnt_reg < START_MIN) begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end else if (cnt_reg >= START_MIN) begin
                        // Start accepted: freeze the frame contents now.
                        state_reg   <= ST_RESP_DELAY;
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        shift_reg   <= frame_data;
                        busy_reg    <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                end
                ST_RESP_DELAY, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW: begin
                    if (phase_done) begin
                        cnt_reg <= '0;
                        case (state_reg)
                            ST_RESP_DELAY: begin
                                state_reg     <= ST_RESP_LOW;
                                drive_low_reg <= 1'b1;
                            end
                            ST_RESP_LOW: begin
                                state_reg     <= ST_RESP_HIGH;
                                drive_low_reg <= 1'b0;
                            end
                            ST_RESP_HIGH: begin
                                state_reg     <= ST_BIT_LOW;
                                drive_low_reg <= 1'b1;
                            end
                            default: begin
                                state_reg     <= ST_BIT_HIGH;
                                drive_low_reg <= 1'b0;
                            end
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_BIT_HIGH: begin
                    if (phase_done) begin
                        cnt_reg       <= '0;
                        shift_reg     <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        bit_idx_reg   <= bit_idx_reg + 6'd1;
                        drive_low_reg <= 1'b1;
                        state_reg     <= (bit_idx_reg == 6'(FRAME_BITS - 1)) ? ST_END_LOW
                                                                              : ST_BIT_LOW;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_END_LOW: begin
                    if (phase_done) begin
                        state_reg       <= ST_IDLE;
                        cnt_reg         <= '0;
                        drive_low_reg   <= 1'b0;
                        busy_reg        <= 1'b0;
                        frame_done_reg  <= 1'b1;
                        frames_sent_reg <= frames_sent_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    drive_low_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;
    assign frames_sent = frames_sent_reg;

endmodule
